// File: rtl/sw_mode_encoder.sv
// sw_mode_encoder: push-button front end for the LED pattern engine.
// Synchronizes and debounces btn[3:0], detects newly pressed buttons and
// latches a one-hot mode code. A press of more than one new button in a
// single debounced event raises err instead of changing the mode.
module sw_mode_encoder #(
  parameter int unsigned DEB_LEN = 1_000_000, // stable cycles to accept a level (>=2)
  parameter int unsigned CNT_W   = 24         // must hold DEB_LEN-1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic [3:0] mode_sel,
  output logic       mode_valid,
  output logic       err,
  output logic [3:0] btn_stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_LEN - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DECODE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q;
  logic [3:0]       s_q;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       captured_q, captured_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mode_sel_q, mode_sel_d;
  logic             mode_valid_d, mode_valid_q;
  logic             err_d, err_q;

  logic [3:0] newp;
  logic       newp_one;
  logic       newp_multi;

  // Buttons newly pressed in the event just accepted; classify as one / many.
  assign newp       = stable_q & ~prev_q;
  assign newp_one   = (newp != 4'b0000) && ((newp & (newp - 4'd1)) == 4'b0000);
  assign newp_multi = (newp != 4'b0000) && !newp_one;

  // State and datapath registers, including the two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync1_q      <= 4'b0000;
      s_q          <= 4'b0000;
      stable_q     <= 4'b0000;
      prev_q       <= 4'b0000;
      captured_q   <= 4'b0000;
      cnt_q        <= '0;
      mode_sel_q   <= 4'b0000;
      mode_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= btn;
      s_q          <= sync1_q;
      stable_q     <= stable_d;
      prev_q       <= prev_d;
      captured_q   <= captured_d;
      cnt_q        <= cnt_d;
      mode_sel_q   <= mode_sel_d;
      mode_valid_q <= mode_valid_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: bounce back to IDLE, restart window on change, or accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_q != stable_q) state_d = COUNT;
      COUNT: begin
        if (s_q == stable_q)                                state_d = IDLE;
        else if (s_q == captured_q && cnt_q == CNT_MAX)     state_d = DECODE;
      end
      DECODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values; pulses default low so they last one cycle.
  always_comb begin
    stable_d     = stable_q;
    prev_d       = prev_q;
    captured_d   = captured_q;
    cnt_d        = cnt_q;
    mode_sel_d   = mode_sel_q;
    mode_valid_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_q != stable_q) begin
          captured_d = s_q;
          cnt_d      = CNT_W'(1);
        end
      end
      COUNT: begin
        if (s_q == stable_q) begin
          cnt_d = '0;
        end else if (s_q != captured_q) begin
          captured_d = s_q;
          cnt_d      = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
          prev_d   = stable_q;
          stable_d = captured_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECODE: begin
        cnt_d = '0;
        if (newp_one) begin
          mode_sel_d   = newp;
          mode_valid_d = 1'b1;
        end else if (newp_multi) begin
          err_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign mode_sel   = mode_sel_q;
  assign mode_valid = mode_valid_q;
  assign err        = err_q;
  assign btn_stable = stable_q;

endmodule
